// File: rtl/maxpool_blk_if.sv
// Sample stream interface for maxpool_blk: conv-side input beats and pooled output beats.
// The master modport is the producer/consumer side; the slave modport is the pooling stage.
interface maxpool_blk_if #(
  parameter int unsigned DATA_WIDTH = 48
);

  logic                         i_en;
  logic signed [DATA_WIDTH-1:0] i_data;
  logic                         o_en;
  logic signed [DATA_WIDTH-1:0] o_data;
  logic                         o_done;

  modport master (
    output i_en,
    output i_data,
    input  o_en,
    input  o_data,
    input  o_done
  );

  modport slave (
    input  i_en,
    input  i_data,
    output o_en,
    output o_data,
    output o_done
  );

endinterface

// File: rtl/maxpool_blk.sv
// Streaming 2x2 / stride-2 max-pool over a raster-order IN_SIZE x IN_SIZE map, using one line buffer.
// Optional MAXPOOL_RELU_EN clamps negative input samples to zero before pooling.
module maxpool_blk #(
  parameter int unsigned IN_SIZE    = 8,
  parameter int unsigned DATA_WIDTH = 48
) (
  input  logic          i_clk,
  input  logic          i_rst,
  maxpool_blk_if.slave  bus
);

  localparam int unsigned HALF     = IN_SIZE / 2;
  localparam int unsigned POOL_LIM = 2 * HALF;
  localparam int unsigned CW       = (IN_SIZE > 2) ? $clog2(IN_SIZE) : 1;
  localparam int unsigned BW       = (HALF > 1) ? $clog2(HALF) : 1;
  localparam bit          ODD_SIZE = (IN_SIZE % 2) != 0;

  localparam logic [CW-1:0] LAST_IDX = CW'(IN_SIZE - 1);
  localparam logic [CW-1:0] LAST_WIN = CW'(POOL_LIM - 1);

  typedef logic signed [DATA_WIDTH-1:0] sample_t;

  function automatic sample_t smax(input sample_t a, input sample_t b);
    return (a > b) ? a : b;
  endfunction

  logic [CW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  sample_t       hold_q, hold_d;
  logic          o_en_q, o_en_d;
  sample_t       o_data_q, o_data_d;
  logic          o_done_q, o_done_d;

  sample_t       line_q [HALF];

  sample_t       sample_c;
  logic          in_win_c;
  logic          last_col_c;
  logic          last_row_c;
  logic [BW-1:0] idx_c;
  logic          buf_we_c;
  sample_t       buf_wd_c;
  sample_t       buf_rd_c;

  // Input conditioning: optional rectification ahead of the window logic.
`ifdef MAXPOOL_RELU_EN
  assign sample_c = bus.i_data[DATA_WIDTH-1] ? '0 : sample_t'(bus.i_data);
`else
  assign sample_c = sample_t'(bus.i_data);
`endif

  assign last_col_c = (col_q == LAST_IDX);
  assign last_row_c = (row_q == LAST_IDX);
  // With an odd side the trailing row/column never completes a window and is dropped.
  assign in_win_c   = !ODD_SIZE || (!last_col_c && !last_row_c);
  assign idx_c      = BW'(col_q >> 1);
  assign buf_rd_c   = line_q[idx_c];

  // Next-state: counters, hold register, line buffer write and pooled output.
  always_comb begin
    row_d    = row_q;
    col_d    = col_q;
    hold_d   = hold_q;
    o_en_d   = 1'b0;
    o_data_d = o_data_q;
    o_done_d = 1'b0;
    buf_we_c = 1'b0;
    buf_wd_c = smax(hold_q, sample_c);

    if (bus.i_en) begin
      if (last_col_c) begin
        col_d = '0;
        row_d = last_row_c ? '0 : CW'(row_q + 1'b1);
      end else begin
        col_d = CW'(col_q + 1'b1);
      end

      if (in_win_c) begin
        unique case ({row_q[0], col_q[0]})
          2'b00: hold_d = sample_c;
          2'b01: buf_we_c = 1'b1;
          2'b10: hold_d = smax(buf_rd_c, sample_c);
          2'b11: begin
            o_en_d   = 1'b1;
            o_data_d = smax(hold_q, sample_c);
            o_done_d = (row_q == LAST_WIN) && (col_q == LAST_WIN);
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      row_q    <= '0;
      col_q    <= '0;
      hold_q   <= '0;
      o_en_q   <= 1'b0;
      o_data_q <= '0;
      o_done_q <= 1'b0;
    end else begin
      row_q    <= row_d;
      col_q    <= col_d;
      hold_q   <= hold_d;
      o_en_q   <= o_en_d;
      o_data_q <= o_data_d;
      o_done_q <= o_done_d;
    end
  end

  // Line buffer of top-row pair maxima; contents are don't-care after reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst && buf_we_c) begin
      line_q[idx_c] <= buf_wd_c;
    end
  end

  assign bus.o_en   = o_en_q;
  assign bus.o_data = o_data_q;
  assign bus.o_done = o_done_q;

endmodule

// File: tb/tb_maxpool_blk.sv
// Directed bench for maxpool_blk: 4x4 and 5x5 instances, gaps, mid-frame reset and back-to-back frames.
module tb_maxpool_blk;

  localparam int unsigned DW = 48;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  maxpool_blk_if #(.DATA_WIDTH(DW)) bus4 ();
  maxpool_blk_if #(.DATA_WIDTH(DW)) bus5 ();

  maxpool_blk #(.IN_SIZE(4), .DATA_WIDTH(DW)) u_dut4 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus4.slave)
  );

  maxpool_blk #(.IN_SIZE(5), .DATA_WIDTH(DW)) u_dut5 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus5.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic signed [63:0] last_val [2];

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input int sel, input logic en, input logic signed [63:0] val);
    if (sel == 0) begin
      bus4.i_en   = en;
      bus4.i_data = DW'(val);
    end else begin
      bus5.i_en   = en;
      bus5.i_data = DW'(val);
    end
  endtask

  task automatic sample_out(input int sel, output logic en, output logic signed [63:0] val,
                            output logic done);
    if (sel == 0) begin
      en = bus4.o_en; val = 64'(bus4.o_data); done = bus4.o_done;
    end else begin
      en = bus5.o_en; val = 64'(bus5.o_data); done = bus5.o_done;
    end
  endtask

  // Idle cycles: no pulse, output data holds its last value.
  task automatic idle(input int sel, input int n);
    logic en, done;
    logic signed [63:0] val;
    for (int k = 0; k < n; k++) begin
      drive(sel, 1'b0, 64'sd0);
      @(negedge clk);
      sample_out(sel, en, val, done);
      check("idle_o_en", 64'(en), 64'd0);
      check("idle_o_data_hold", val, last_val[sel]);
    end
  endtask

  // Sends n pixels base+step*i on an sz x sz map; e0..e3 are the hand-computed window maxima in order.
  task automatic send_frame(input int sel, input int sz, input int n, input longint base, input longint step,
                            input int gap, input longint e0, input longint e1, input longint e2,
                            input longint e3);
    longint exp_v [4];
    int h, win, r, c;
    logic cmpl, en, done;
    logic signed [63:0] val;
    exp_v[0] = e0; exp_v[1] = e1; exp_v[2] = e2; exp_v[3] = e3;
    h   = sz / 2;
    win = 0;
    for (int i = 0; i < n; i++) begin
      r = i / sz;
      c = i % sz;
      cmpl = (r % 2 == 1) && (c % 2 == 1) && (r < 2 * h) && (c < 2 * h);
      drive(sel, 1'b1, 64'(base + step * longint'(i)));
      @(negedge clk);
      sample_out(sel, en, val, done);
      drive(sel, 1'b0, 64'sd0);
      check($sformatf("o_en_px%0d", i), 64'(en), 64'(cmpl));
      if (cmpl) begin
        check($sformatf("o_data_px%0d", i), val, exp_v[win]);
        check($sformatf("o_done_px%0d", i), 64'(done), 64'(win == h * h - 1));
        last_val[sel] = exp_v[win];
        win++;
      end else begin
        check($sformatf("o_done_px%0d", i), 64'(done), 64'd0);
      end
      if (gap > 0) idle(sel, gap);
    end
  endtask

  initial begin
    bus4.i_en = 1'b0; bus4.i_data = '0;
    bus5.i_en = 1'b0; bus5.i_data = '0;
    last_val[0] = 0;
    last_val[1] = 0;

    // Reset, with a valid beat presented during reset that must be ignored.
    repeat (2) @(negedge clk);
    drive(0, 1'b1, 64'sd77);
    drive(1, 1'b1, 64'sd77);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1'b0, 64'sd0);
    drive(1, 1'b0, 64'sd0);
    check("rst_o_en4", 64'(bus4.o_en), 64'd0);
    check("rst_o_data4", 64'(bus4.o_data), 64'sd0);
    check("rst_o_done4", 64'(bus4.o_done), 64'd0);
    check("rst_o_en5", 64'(bus5.o_en), 64'd0);
    check("rst_o_data5", 64'(bus5.o_data), 64'sd0);
    check("rst_o_done5", 64'(bus5.o_done), 64'd0);

    send_frame(0, 4, 16, 0, 1, 0, 5, 7, 13, 15);
    idle(0, 2);

`ifdef MAXPOOL_RELU_EN
    send_frame(0, 4, 16, -1, -1, 0, 0, 0, 0, 0);
`else
    send_frame(0, 4, 16, -1, -1, 0, -1, -3, -9, -11);
`endif
    idle(0, 2);

    send_frame(1, 5, 25, 0, 1, 0, 6, 8, 16, 18);
    idle(1, 2);

    send_frame(0, 4, 16, 0, 1, 3, 5, 7, 13, 15);

    // Partial frame, then one reset cycle with a concurrent beat that is ignored.
    send_frame(0, 4, 7, 0, 1, 0, 5, 0, 0, 0);
    rst = 1'b1;
    drive(0, 1'b1, 64'sd999);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1'b0, 64'sd0);
    check("midrst_o_en", 64'(bus4.o_en), 64'd0);
    check("midrst_o_data", 64'(bus4.o_data), 64'sd0);
    last_val[0] = 0;
    send_frame(0, 4, 16, 100, 1, 0, 105, 107, 113, 115);

    send_frame(0, 4, 16, 0, 1, 0, 5, 7, 13, 15);
    send_frame(0, 4, 16, 16, 1, 0, 21, 23, 29, 31);
    idle(0, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
